// File: rtl/i2c_master_ctrl_if.sv
// Command/status side of the I2C master: one-cycle command in, busy/done/status and read bytes out.
interface i2c_master_ctrl_if #(
    parameter int ADDR_LEN = 7,
    parameter int DATA_LEN = 8
);
    logic                start;
    logic                rw;
    logic [ADDR_LEN-1:0] addr;
    logic [DATA_LEN-1:0] wdata1;
    logic [DATA_LEN-1:0] wdata2;
    logic                busy;
    logic                done;
    logic                ack_err;
    logic [DATA_LEN-1:0] rdata1;
    logic [DATA_LEN-1:0] rdata2;

    // master issues commands; slave is the controller that executes them on the bus
    modport master (output start, rw, addr, wdata1, wdata2,
                    input  busy, done, ack_err, rdata1, rdata2);
    modport slave  (input  start, rw, addr, wdata1, wdata2,
                    output busy, done, ack_err, rdata1, rdata2);
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: START, address+rw, two data bytes with ACK handling, STOP.
module i2c_master_ctrl #(
    parameter int ADDR_LEN = 7,
    parameter int DATA_LEN = 8,
    parameter int CLK_DIV  = 4
) (
    input  logic             clk,
    input  logic             rst,
    i2c_master_ctrl_if.slave cmd,
    output logic             scl,
    inout  wire              sda
);
    localparam int SR_W  = (ADDR_LEN + 1 > DATA_LEN) ? ADDR_LEN + 1 : DATA_LEN;
    localparam int CNT_W = $clog2(SR_W);
    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR1, WR1_ACK, WR2, WR2_ACK,
        RD1, RD1_ACK, RD2, RD2_NACK, STOP
    } state_t;

    state_t              state, state_d;
    logic [DIV_W-1:0]    div_q;
    logic [1:0]          q;
    logic [CNT_W-1:0]    bitcnt;
    logic [SR_W-1:0]     tx_sr;
    logic                rw_q;
    logic [DATA_LEN-1:0] wd1_q, wd2_q;
    logic                sda_low, sda_low_d;
    logic                busy, done, ack_err;
    logic [DATA_LEN-1:0] rdata1, rdata2;
    logic                sda_in;
    logic                tick, q1_entry, q2_entry, q3_entry, bit_end, last, accept;

    assign tick     = (div_q == DIV_W'(CLK_DIV - 1));
    assign q1_entry = tick && (q == 2'd0);
    assign q2_entry = tick && (q == 2'd1);
    assign q3_entry = tick && (q == 2'd2);
    assign bit_end  = tick && (q == 2'd3);
    assign last     = (bitcnt == '0);
    assign accept   = (state == IDLE) && cmd.start;

    // SCL stays high through IDLE/START; every other bit is low for q0-q1, high for q2-q3
    assign scl    = (state == IDLE) || (state == START) || q[1];
    assign sda    = sda_low ? 1'b0 : 1'bz;
    assign sda_in = sda;

    assign cmd.busy    = busy;
    assign cmd.done    = done;
    assign cmd.ack_err = ack_err;
    assign cmd.rdata1  = rdata1;
    assign cmd.rdata2  = rdata2;

    always_comb begin
        state_d   = state;
        sda_low_d = sda_low;
        case (state)
            IDLE: begin
                sda_low_d = 1'b0;
                if (cmd.start) state_d = START;
            end
            START: begin
                if (q2_entry) sda_low_d = 1'b1;
                if (bit_end)  state_d = ADDR;
            end
            ADDR, WR1, WR2: begin
                if (q1_entry) sda_low_d = ~tx_sr[SR_W-1];
                if (bit_end && last)
                    state_d = (state == ADDR) ? ADDR_ACK : (state == WR1) ? WR1_ACK : WR2_ACK;
            end
            ADDR_ACK: begin
                if (q1_entry) sda_low_d = 1'b0;
                if (bit_end)  state_d = ack_err ? STOP : (rw_q ? RD1 : WR1);
            end
            WR1_ACK: begin
                if (q1_entry) sda_low_d = 1'b0;
                if (bit_end)  state_d = ack_err ? STOP : WR2;
            end
            WR2_ACK, RD2_NACK: begin
                if (q1_entry) sda_low_d = 1'b0;
                if (bit_end)  state_d = STOP;
            end
            RD1, RD2: begin
                if (q1_entry) sda_low_d = 1'b0;
                if (bit_end && last) state_d = (state == RD1) ? RD1_ACK : RD2_NACK;
            end
            RD1_ACK: begin
                if (q1_entry) sda_low_d = 1'b1;
                if (bit_end)  state_d = RD2;
            end
            STOP: begin
                if (q3_entry) sda_low_d = 1'b0;
                if (bit_end)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // STOP pulls SDA low together with the SCL fall so the final rise happens with SCL high
        if (state_d == STOP && state != STOP) sda_low_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            div_q   <= '0;
            q       <= '0;
            bitcnt  <= '0;
            tx_sr   <= '0;
            rw_q    <= 1'b0;
            wd1_q   <= '0;
            wd2_q   <= '0;
            sda_low <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ack_err <= 1'b0;
            rdata1  <= '0;
            rdata2  <= '0;
        end else begin
            state   <= state_d;
            sda_low <= sda_low_d;
            done    <= (state == STOP) && bit_end;
            busy    <= (state != IDLE) && !((state == STOP) && bit_end);
            if (state == IDLE) begin
                div_q <= '0;
                q     <= '0;
            end else begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) q <= q + 2'd1;
            end
            if (accept) begin
                rw_q    <= cmd.rw;
                wd1_q   <= cmd.wdata1;
                wd2_q   <= cmd.wdata2;
                tx_sr   <= SR_W'({cmd.addr, cmd.rw}) << (SR_W - ADDR_LEN - 1);
                bitcnt  <= CNT_W'(ADDR_LEN);
                ack_err <= 1'b0;
            end else if (bit_end) begin
                // counter reloads on every state change, so it never wraps inside a byte
                if (state_d != state) begin
                    bitcnt <= (state_d == ADDR) ? CNT_W'(ADDR_LEN) : CNT_W'(DATA_LEN - 1);
                    if (state_d == WR1) tx_sr <= SR_W'(wd1_q) << (SR_W - DATA_LEN);
                    if (state_d == WR2) tx_sr <= SR_W'(wd2_q) << (SR_W - DATA_LEN);
                end else begin
                    bitcnt <= bitcnt - 1'b1;
                    tx_sr  <= tx_sr << 1;
                end
            end
            if (q3_entry && sda_in &&
                (state == ADDR_ACK || state == WR1_ACK || state == WR2_ACK))
                ack_err <= 1'b1;
            if (q3_entry && state == RD1) rdata1 <= {rdata1[DATA_LEN-2:0], sda_in};
            if (q3_entry && state == RD2) rdata2 <= {rdata2[DATA_LEN-2:0], sda_in};
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a behavioural bus slave and SCL/SDA timing monitor.
module tb_i2c_master_ctrl;
    localparam int CLK_DIV = 4;
    localparam int BITP    = 4 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl;
    wire  sda;
    logic slv_low = 1'b0;

    always #5 clk = ~clk;

    pullup (sda);
    assign sda = slv_low ? 1'b0 : 1'bz;

    i2c_master_ctrl_if #(.ADDR_LEN(7), .DATA_LEN(8)) cmd ();
    i2c_master_ctrl #(.ADDR_LEN(7), .DATA_LEN(8), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .cmd(cmd.slave), .scl(scl), .sda(sda));

    int checks = 0;
    int failures = 0;

    // slave configuration
    logic       sl_resp = 1'b0, sl_nack1 = 1'b0;
    logic [7:0] sl_r1 = '0, sl_r2 = '0;

    // slave / monitor state
    int         cyc = 0, sl_n = 0, sl_nb = 0, apl = 0, sf = 0, last_rise = 0;
    int         hi_chg = 0, viol = 0, done_cnt = 0;
    logic       scl_d = 1'b1, sda_d = 1'b1, sl_act = 1'b0, sl_rd = 1'b0, rise_ok = 1'b0;
    logic       sl_a18 = 1'b1, sl_a27 = 1'b0;
    logic [7:0] sl_rx = '0, sl_b0 = '0, sl_b1 = '0, sl_b2 = '0;
    logic [7:0] rxn;
    assign rxn = {sl_rx[6:0], sda};

    function automatic logic sl_drive(input int n);
        logic [7:0] t;
        if (n == 8) return sl_resp;
        if (sl_rd && n >= 9 && n <= 16) begin t = sl_r1 >> (16 - n); return !t[0]; end
        if (sl_rd && n >= 18 && n <= 25) begin t = sl_r2 >> (25 - n); return !t[0]; end
        if (!sl_rd && n == 17) return sl_resp && !sl_nack1;
        if (!sl_rd && n == 26) return sl_resp;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        scl_d <= scl;
        sda_d <= sda;
        if (cmd.done) done_cnt <= done_cnt + 1;
        if (rst) begin
            sl_act  <= 1'b0;
            slv_low <= 1'b0;
            apl     <= 0;
            rise_ok <= 1'b0;
        end else if (scl && scl_d && sda_d && !sda) begin
            sl_act <= 1'b1; sl_n <= 0; sl_nb <= 0; rise_ok <= 1'b0; hi_chg <= hi_chg + 1;
        end else if (scl && scl_d && !sda_d && sda) begin
            sl_act <= 1'b0; slv_low <= 1'b0; hi_chg <= hi_chg + 1;
        end else begin
            if (scl_d && !scl) begin
                apl <= 3;
                sf  <= 1;
                if (rise_ok && (cyc - last_rise) != BITP / 2) viol <= viol + 1;
            end else begin
                sf <= sf + 1;
                if (apl != 0) begin
                    apl <= apl - 1;
                    if (apl == 1 && sl_act) slv_low <= sl_drive(sl_n);
                end
            end
            if (!scl_d && scl && sl_act) begin
                sl_rx <= rxn;
                sl_n  <= sl_n + 1;
                if (sl_n == 7)  begin sl_b0 <= rxn; sl_rd <= sda; sl_nb <= sl_nb + 1; end
                if (sl_n == 16) begin sl_b1 <= rxn; sl_nb <= sl_nb + 1; end
                if (sl_n == 25) begin sl_b2 <= rxn; sl_nb <= sl_nb + 1; end
                if (sl_n == 17) sl_a18 <= sda;
                if (sl_n == 26) sl_a27 <= sda;
                if (rise_ok && (cyc - last_rise) != BITP) viol <= viol + 1;
                last_rise <= cyc;
                rise_ok   <= 1'b1;
            end
            // SDA may move with SCL low only CLK_DIV clocks after the SCL fall
            if (!scl_d && !scl && sda_d != sda && sl_act && sf != CLK_DIV) viol <= viol + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wd1, wd2;
        logic       resp, nack1;
        logic [7:0] r1, r2;
        int         lat;
        logic       err;
        int         err_at, nb;
        logic [7:0] b0, b1, b2, rd1, rd2;
    } vec_t;

    vec_t tv[6];

    task automatic run(input vec_t v, input string nm, input int dup_at);
        int n, err_at, d0, h0, v0;
        sl_resp = v.resp; sl_nack1 = v.nack1; sl_r1 = v.r1; sl_r2 = v.r2;
        d0 = done_cnt; h0 = hi_chg; v0 = viol;
        @(negedge clk);
        cmd.start = 1'b1; cmd.rw = v.rw; cmd.addr = v.addr;
        cmd.wdata1 = v.wd1; cmd.wdata2 = v.wd2;
        @(posedge clk); #1;
        cmd.start = 1'b0;
        chk({nm, "_busy_at_accept"}, cmd.busy, 0);
        n = 0; err_at = 0;
        while (n < 2000) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) chk({nm, "_busy_next"}, cmd.busy, 1);
            if (n == dup_at) begin cmd.start = 1'b1; cmd.addr = 7'h11; end
            else cmd.start = 1'b0;
            if (cmd.ack_err && err_at == 0) err_at = n;
            if (cmd.done) break;
        end
        chk({nm, "_latency"}, n, v.lat);
        chk({nm, "_busy_at_done"}, cmd.busy, 0);
        chk({nm, "_ack_err"}, cmd.ack_err, v.err);
        chk({nm, "_ack_err_cycle"}, err_at, v.err_at);
        chk({nm, "_rdata1"}, cmd.rdata1, v.rd1);
        chk({nm, "_rdata2"}, cmd.rdata2, v.rd2);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, cmd.done, 0);
        repeat (4) @(posedge clk);
        #1;
        chk({nm, "_done_count"}, done_cnt - d0, 1);
        chk({nm, "_bytes_seen"}, sl_nb, v.nb);
        chk({nm, "_bus_addr"}, sl_b0, v.b0);
        if (v.nb >= 2) chk({nm, "_bus_byte1"}, sl_b1, v.b1);
        if (v.nb >= 3) chk({nm, "_bus_byte2"}, sl_b2, v.b2);
        if (v.rw && v.nb == 3) begin
            chk({nm, "_master_ack_bit18"}, sl_a18, 0);
            chk({nm, "_master_nack_bit27"}, sl_a27, 1);
        end
        chk({nm, "_start_stop_edges"}, hi_chg - h0, 2);
        chk({nm, "_bit_timing"}, viol - v0, 0);
    endtask

    initial begin
        vec_t v;
        cmd.start = 1'b0; cmd.rw = 1'b0; cmd.addr = '0; cmd.wdata1 = '0; cmd.wdata2 = '0;
        //        rw  addr   wd1    wd2    resp nack r1     r2     lat  err err_at nb b0     b1     b2     rd1    rd2
        tv[0] = '{1'b0, 7'h5B, 8'hA5, 8'h3C, 1'b1, 1'b0, 8'h00, 8'h00, 464, 1'b0, 0,   3, 8'hB6, 8'hA5, 8'h3C, 8'h00, 8'h00};
        tv[1] = '{1'b1, 7'h5B, 8'h00, 8'h00, 1'b1, 1'b0, 8'hC3, 8'h5A, 464, 1'b0, 0,   3, 8'hB7, 8'hC3, 8'h5A, 8'hC3, 8'h5A};
        tv[2] = '{1'b0, 7'h12, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 8'h00, 176, 1'b1, 156, 1, 8'h24, 8'h00, 8'h00, 8'hC3, 8'h5A};
        tv[3] = '{1'b0, 7'h5B, 8'h0F, 8'hF0, 1'b1, 1'b1, 8'h00, 8'h00, 320, 1'b1, 300, 2, 8'hB6, 8'h0F, 8'h00, 8'hC3, 8'h5A};
        tv[4] = '{1'b1, 7'h7F, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h80, 464, 1'b0, 0,   3, 8'hFF, 8'h01, 8'h80, 8'h01, 8'h80};
        tv[5] = '{1'b0, 7'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 464, 1'b0, 0,   3, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h80};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_scl", scl, 1);
        chk("reset_sda", sda, 1);
        chk("reset_busy", cmd.busy, 0);
        chk("reset_done", cmd.done, 0);
        chk("reset_ack_err", cmd.ack_err, 0);
        chk("reset_rdata", {cmd.rdata1, cmd.rdata2}, 0);

        // start in the same cycle as rst is dropped
        @(negedge clk);
        cmd.start = 1'b1; cmd.addr = 7'h5B;
        @(posedge clk); #1;
        rst = 1'b0; cmd.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("start_with_rst_busy", cmd.busy, 0);
        chk("start_with_rst_scl", scl, 1);

        for (int i = 0; i < 6; i++) run(tv[i], $sformatf("vec%0d", i), 0);

        // second start while busy is ignored
        run(tv[5], "dup_start", 100);

        // rst in the middle of a write
        @(negedge clk);
        sl_resp = 1'b1; sl_nack1 = 1'b0;
        cmd.start = 1'b1; cmd.rw = 1'b0; cmd.addr = 7'h12; cmd.wdata1 = 8'h55; cmd.wdata2 = 8'hAA;
        @(posedge clk); #1;
        cmd.start = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda, 1);
        chk("midrst_busy", cmd.busy, 0);
        chk("midrst_ack_err", cmd.ack_err, 0);
        chk("midrst_done", cmd.done, 0);
        repeat (20) @(posedge clk);
        v = tv[0];
        run(v, "after_rst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
